pc_fetch: RTL and testbench



---
 rtl/pc_fetch.sv | 117 +++++++++++
 tb/tb_pc_fetch.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch.sv
// pc_fetch: program counter and single-outstanding instruction fetch into a small decode queue.
// Optional misaligned-redirect trap enabled by defining PC_FETCH_ALIGN_CHK_EN.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redir_valid,
  input  logic [31:0] redir_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        dec_valid,
  output logic [31:0] dec_pc,
  output logic [31:0] dec_ins,
  input  logic        dec_ready,
  output logic [31:0] pc_out
`ifdef PC_FETCH_ALIGN_CHK_EN
  ,
  output logic        fetch_exc
`endif
);
  localparam logic [2:0] DEPTH = 3'(QDEPTH);
  localparam logic [1:0] LAST  = 2'(QDEPTH - 1);
  typedef enum logic [1:0] {
    S_BOOT,
    S_REQ,
    S_WAIT
`ifdef PC_FETCH_ALIGN_CHK_EN
    ,
    S_HALT
`endif
  } state_t;
  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_drop;
  logic [2:0]  r_count;
  logic [1:0]  r_rd;
  logic [1:0]  r_wr;
  logic [31:0] r_q_pc  [4];
  logic [31:0] r_q_ins [4];
  logic        w_gnt;
  logic        w_busy;
  logic        w_rsp;
  logic        w_outst;
  logic        w_push;
  logic        w_pop;
  logic [31:0] w_rpc;
`ifdef PC_FETCH_ALIGN_CHK_EN
  logic        w_misal;
  assign w_misal = redir_pc[1:0] != 2'b00;
  assign w_rpc   = redir_pc;
  assign w_busy  = (r_state == S_WAIT) || ((r_state == S_HALT) && r_drop);
`else
  assign w_rpc   = redir_pc & 32'hFFFF_FFFC;
  assign w_busy  = r_state == S_WAIT;
`endif
  // Credit rule: only request while the queue has room for the response.
  assign imem_req  = (r_state == S_REQ) && (r_count < DEPTH);
  assign imem_addr = {r_pc[31:2], 2'b00};
  assign pc_out    = r_pc;
  assign dec_valid = r_count != 3'd0;
  assign dec_pc    = r_q_pc[r_rd];
  assign dec_ins   = r_q_ins[r_rd];
  assign w_gnt     = imem_req & imem_gnt;
  assign w_rsp     = imem_rvalid & w_busy;
  assign w_outst   = w_gnt | (w_busy & ~imem_rvalid);
  assign w_push    = w_rsp & ~r_drop & ~redir_valid;
  assign w_pop     = dec_valid & dec_ready & ~redir_valid;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_BOOT;
      r_pc    <= RESET_PC;
      r_drop  <= 1'b0;
      r_count <= 3'd0;
      r_rd    <= 2'd0;
      r_wr    <= 2'd0;
      for (int i = 0; i < 4; i++) begin
        r_q_pc[i]  <= 32'd0;
        r_q_ins[i] <= 32'd0;
      end
`ifdef PC_FETCH_ALIGN_CHK_EN
      fetch_exc <= 1'b0;
`endif
    end else begin
      if (w_push) begin
        r_q_pc[r_wr]  <= r_pc;
        r_q_ins[r_wr] <= imem_rdata;
      end
      if (redir_valid) begin
        r_pc    <= w_rpc;
        r_drop  <= w_outst;
        r_count <= 3'd0;
        r_rd    <= 2'd0;
        r_wr    <= 2'd0;
`ifdef PC_FETCH_ALIGN_CHK_EN
        r_state   <= w_misal ? S_HALT : w_outst ? S_WAIT : S_REQ;
        fetch_exc <= w_misal;
`else
        r_state <= w_outst ? S_WAIT : S_REQ;
`endif
      end else begin
        r_count <= r_count + 3'(w_push) - 3'(w_pop);
        if (w_push) r_wr <= (r_wr == LAST) ? 2'd0 : r_wr + 2'd1;
        if (w_pop) r_rd <= (r_rd == LAST) ? 2'd0 : r_rd + 2'd1;
        if (w_push) r_pc <= r_pc + 32'd4;
        if (w_rsp) r_drop <= 1'b0;
        r_state <= (r_state == S_BOOT) ? S_REQ :
                   w_gnt ? S_WAIT :
                   ((r_state == S_WAIT) && w_rsp) ? S_REQ : r_state;
      end
    end
  end
endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: directed checks of pc_fetch with a one-cycle instruction memory model.
module tb_pc_fetch;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        dec_valid;
  logic [31:0] dec_pc;
  logic [31:0] dec_ins;
  logic        dec_ready;
  logic [31:0] pc_out;
`ifdef PC_FETCH_ALIGN_CHK_EN
  logic        fetch_exc;
`endif
  int          n_chk = 0;
  int          n_fail = 0;
  logic        pend;
  logic [31:0] pend_addr;
  logic        auto_rsp;
  pc_fetch dut (
    .clk(clk), .rst_n(rst_n), .redir_valid(redir_valid), .redir_pc(redir_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .dec_valid(dec_valid),
    .dec_pc(dec_pc), .dec_ins(dec_ins), .dec_ready(dec_ready), .pc_out(pc_out)
`ifdef PC_FETCH_ALIGN_CHK_EN
    , .fetch_exc(fetch_exc)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // One cycle of the memory model: grant whatever is requested, answer one cycle later.
  task automatic tick();
    logic        g;
    logic [31:0] a;
    imem_gnt    = imem_req;
    imem_rvalid = pend & auto_rsp;
    imem_rdata  = {16'hC0DE, pend_addr[15:0]};
    g = imem_gnt;
    a = imem_addr;
    @(posedge clk);
    if (imem_rvalid) pend = 1'b0;
    if (g) begin
      pend      = 1'b1;
      pend_addr = a;
    end
    @(negedge clk);
  endtask
  task automatic do_reset();
    rst_n       = 1'b0;
    pend        = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    redir_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic redirect(input logic [31:0] pc);
    redir_valid = 1'b1;
    redir_pc    = pc;
    tick();
    redir_valid = 1'b0;
  endtask
  initial begin
    rst_n = 1'b0; redir_valid = 1'b0; redir_pc = 32'd0; imem_gnt = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = 32'd0; dec_ready = 1'b1;
    pend = 1'b0; pend_addr = 32'd0; auto_rsp = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_dv", 32'(dec_valid), 32'd0);
    chk("rst_dpc", dec_pc, 32'd0);
    chk("rst_dins", dec_ins, 32'd0);
    chk("rst_pc", pc_out, 32'h3000);
    rst_n = 1'b1;
    tick();
    chk("boot_req", 32'(imem_req), 32'd1);
    chk("boot_addr", imem_addr, 32'h3000);
    tick();
    chk("wait_req", 32'(imem_req), 32'd0);
    tick();
    chk("first_dv", 32'(dec_valid), 32'd1);
    chk("first_dpc", dec_pc, 32'h3000);
    chk("first_dins", dec_ins, 32'hC0DE_3000);
    repeat (2) tick();
    chk("seq_dpc1", dec_pc, 32'h3004);
    repeat (2) tick();
    chk("seq_dpc2", dec_pc, 32'h3008);
    chk("seq_dins2", dec_ins, 32'hC0DE_3008);
    dec_ready = 1'b0;
    do_reset();
    repeat (5) tick();
    chk("bp_req", 32'(imem_req), 32'd0);
    chk("bp_dpc", dec_pc, 32'h3000);
    chk("bp_pc", pc_out, 32'h3008);
    repeat (3) tick();
    chk("bp_hold_req", 32'(imem_req), 32'd0);
    chk("bp_hold_dpc", dec_pc, 32'h3000);
    dec_ready = 1'b1;
    tick();
    chk("drain_dpc", dec_pc, 32'h3004);
    chk("drain_req", 32'(imem_req), 32'd1);
    chk("drain_addr", imem_addr, 32'h3008);
    tick();
    chk("drain_empty", 32'(dec_valid), 32'd0);
    tick();
    chk("resume_dpc", dec_pc, 32'h3008);
    do_reset();
    repeat (2) tick();
    auto_rsp = 1'b0;
    redirect(32'h4000);
    chk("rw_pc", pc_out, 32'h4000);
    chk("rw_req", 32'(imem_req), 32'd0);
    chk("rw_dv", 32'(dec_valid), 32'd0);
    tick();
    auto_rsp = 1'b1;
    tick();
    chk("rw_drop_dv", 32'(dec_valid), 32'd0);
    chk("rw_next_req", 32'(imem_req), 32'd1);
    chk("rw_next_addr", imem_addr, 32'h4000);
    repeat (2) tick();
    chk("rw_dpc", dec_pc, 32'h4000);
    chk("rw_dins", dec_ins, 32'hC0DE_4000);
    tick();
    redirect(32'h5000);
    chk("rv_dv", 32'(dec_valid), 32'd0);
    chk("rv_req", 32'(imem_req), 32'd1);
    chk("rv_addr", imem_addr, 32'h5000);
    repeat (2) tick();
    chk("rv_dpc", dec_pc, 32'h5000);
    chk("rv_dins", dec_ins, 32'hC0DE_5000);
    redirect(32'h6000);
    chk("rg_dv", 32'(dec_valid), 32'd0);
    chk("rg_req", 32'(imem_req), 32'd0);
    chk("rg_pc", pc_out, 32'h6000);
    tick();
    chk("rg_drop_dv", 32'(dec_valid), 32'd0);
    chk("rg_addr", imem_addr, 32'h6000);
    redirect(32'hFFFF_FFFC);
    tick();
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    repeat (2) tick();
    chk("wrap_dpc", dec_pc, 32'hFFFF_FFFC);
    chk("wrap_addr1", imem_addr, 32'h0000_0000);
`ifdef PC_FETCH_ALIGN_CHK_EN
    redirect(32'h4002);
    chk("exc_set", 32'(fetch_exc), 32'd1);
    chk("halt_req", 32'(imem_req), 32'd0);
    chk("halt_dv", 32'(dec_valid), 32'd0);
    repeat (3) tick();
    chk("halt_hold_req", 32'(imem_req), 32'd0);
    chk("halt_hold_dv", 32'(dec_valid), 32'd0);
    redirect(32'h4004);
    chk("exc_clr", 32'(fetch_exc), 32'd0);
    chk("unhalt_req", 32'(imem_req), 32'd1);
    chk("unhalt_addr", imem_addr, 32'h4004);
`else
    redirect(32'h7002);
    tick();
    chk("mis_addr", imem_addr, 32'h7000);
    chk("mis_pc", pc_out, 32'h7000);
`endif
    tick();
    rst_n = 1'b0;
    #1;
    chk("mr_req", 32'(imem_req), 32'd0);
    chk("mr_pc", pc_out, 32'h3000);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("mr_stale_dv", 32'(dec_valid), 32'd0);
    chk("mr_req2", 32'(imem_req), 32'd1);
    chk("mr_addr", imem_addr, 32'h3000);
    repeat (2) tick();
    chk("mr_dpc", dec_pc, 32'h3000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
